// File: rtl/alu_pkg.sv
// Shared constants, instruction layout and decode helpers for the ALU operand-fetch stage.
package alu_pkg;

   localparam int W    = 16;
   localparam int NREG = 8;
   localparam int RW   = 3;
   localparam int OPW  = 4;

   // ALU opcodes
   localparam logic [OPW-1:0] ALU_ADD  = 4'd0;
   localparam logic [OPW-1:0] ALU_SUB  = 4'd1;
   localparam logic [OPW-1:0] ALU_AND  = 4'd2;
   localparam logic [OPW-1:0] ALU_OR   = 4'd3;
   localparam logic [OPW-1:0] ALU_EPAR = 4'd4;

   // Instruction field positions
   localparam int OP_HI   = 15;
   localparam int OP_LO   = 12;
   localparam int RD_HI   = 11;
   localparam int RD_LO   = 9;
   localparam int RA_HI   = 8;
   localparam int RA_LO   = 6;
   localparam int RB_HI   = 5;
   localparam int RB_LO   = 3;
   localparam int IMM_BIT = 2;

   typedef struct packed {
      logic [OPW-1:0] op;
      logic [RW-1:0]  rd;
      logic [RW-1:0]  ra;
      logic [RW-1:0]  rb;
      logic           imm;
   } instr_t;

   // Split a raw instruction word into its fields; bits [1:0] are unused.
   function automatic instr_t decode(input logic [W-1:0] word);
      instr_t d;
      d.op  = word[OP_HI:OP_LO];
      d.rd  = word[RD_HI:RD_LO];
      d.ra  = word[RA_HI:RA_LO];
      d.rb  = word[RB_HI:RB_LO];
      d.imm = word[IMM_BIT];
      return d;
   endfunction

   // True for opcodes the downstream ALU implements.
   function automatic logic op_legal(input logic [OPW-1:0] o);
      logic ok;
      case (o)
         ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_EPAR: ok = 1'b1;
         default:                                     ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/reg_file_8x16.sv
// 8x16 register file: two combinational read ports, one synchronous write port.
// r0 has no storage and always reads zero; writes to it are discarded.
module reg_file_8x16
   import alu_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   input  logic [RW-1:0] ra_addr,
   input  logic [RW-1:0] rb_addr,
   output logic [W-1:0]  ra_data,
   output logic [W-1:0]  rb_data,
   input  logic          we,
   input  logic [RW-1:0] waddr,
   input  logic [W-1:0]  wdata
);

   logic [W-1:0] regs [NREG-1:1];

   // Storage update: clear everything on reset, otherwise write any register except r0.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 1; i < NREG; i++) begin
            regs[i] <= 16'd0;
         end
      end else if (we && (waddr != 3'd0)) begin
         regs[waddr] <= wdata;
      end
   end

   // Read ports: r0 is hardwired to zero.
   always_comb begin
      ra_data = 16'd0;
      rb_data = 16'd0;
      if (ra_addr != 3'd0) begin
         ra_data = regs[ra_addr];
      end else begin
         ra_data = 16'd0;
      end
      if (rb_addr != 3'd0) begin
         rb_data = regs[rb_addr];
      end else begin
         rb_data = 16'd0;
      end
   end

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand fetch / issue stage feeding the 16-bit ALU.
// Decodes instructions, reads the register file, tracks in-flight destinations
// in a pending scoreboard and presents a registered operand bundle.
// Optional build macro: ALU_OPF_FWD_EN enables same-cycle writeback bypass.
module alu_operand_fetch
   import alu_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   input  logic           instr_valid,
   output logic           instr_ready,
   input  logic [W-1:0]   instr,
   output logic [W-1:0]   input_a,
   output logic [W-1:0]   input_b,
   output logic [OPW-1:0] op,
   output logic [RW-1:0]  out_rd,
   output logic           out_valid,
   input  logic           out_ready,
   input  logic           wb_en,
   input  logic [RW-1:0]  wb_addr,
   input  logic [W-1:0]   wb_data,
   output logic           err
);

   instr_t          dec;
   logic [NREG-1:0] pending;
   logic [NREG-1:0] pending_next;
   logic [NREG-1:0] pend_view;
   logic            hazard;
   logic            accept;
   logic            legal;
   logic [W-1:0]    rf_a;
   logic [W-1:0]    rf_b;
   logic [W-1:0]    opnd_a;
   logic [W-1:0]    opnd_b;

   reg_file_8x16 u_rf (
      .clock   (clock),
      .reset   (reset),
      .ra_addr (dec.ra),
      .rb_addr (dec.rb),
      .ra_data (rf_a),
      .rb_data (rf_b),
      .we      (wb_en),
      .waddr   (wb_addr),
      .wdata   (wb_data)
   );

   // Decode the incoming instruction word.
   always_comb begin
      dec   = decode(instr);
      legal = op_legal(dec.op);
   end

   // Hazard detection against the scoreboard; rb only matters for register operands.
   always_comb begin
      pend_view = pending;
`ifdef ALU_OPF_FWD_EN
      if (wb_en) begin
         pend_view[wb_addr] = 1'b0;
      end else begin
         pend_view = pending;
      end
`endif
      hazard = pend_view[dec.ra] | pend_view[dec.rd] | (~dec.imm & pend_view[dec.rb]);
   end

   assign instr_ready = !reset && (!out_valid || out_ready) && !hazard;
   assign accept      = instr_valid && instr_ready;

   // Operand selection: B is the zero-extended rb field in immediate mode.
   always_comb begin
      opnd_a = rf_a;
      if (dec.imm) begin
         opnd_b = {13'd0, dec.rb};
      end else begin
         opnd_b = rf_b;
      end
`ifdef ALU_OPF_FWD_EN
      if (wb_en && (wb_addr != 3'd0) && (wb_addr == dec.ra)) begin
         opnd_a = wb_data;
      end else begin
         opnd_a = rf_a;
      end
      if (!dec.imm && wb_en && (wb_addr != 3'd0) && (wb_addr == dec.rb)) begin
         opnd_b = wb_data;
      end else begin
         opnd_b = opnd_b;
      end
`endif
   end

   // Scoreboard next state: writeback clears, a legal accept sets (set wins).
   always_comb begin
      pending_next = pending;
      if (wb_en) begin
         pending_next[wb_addr] = 1'b0;
      end else begin
         pending_next = pending;
      end
      if (accept && legal && (dec.rd != 3'd0)) begin
         pending_next[dec.rd] = 1'b1;
      end else begin
         pending_next = pending_next;
      end
      pending_next[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clock) begin
      if (reset) begin
         pending <= 8'd0;
      end else begin
         pending <= pending_next;
      end
   end

   // Output bundle register, valid flag and illegal-opcode pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         input_a   <= 16'd0;
         input_b   <= 16'd0;
         op        <= 4'd0;
         out_rd    <= 3'd0;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= accept && !legal;
         if (accept && legal) begin
            input_a   <= opnd_a;
            input_b   <= opnd_b;
            op        <= dec.op;
            out_rd    <= dec.rd;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed self-checking bench for alu_operand_fetch.
// Honours ALU_OPF_FWD_EN for the same-cycle writeback expectations.
module tb_alu_operand_fetch;

   logic        clock = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [15:0] input_a;
   logic [15:0] input_b;
   logic [3:0]  op;
   logic [2:0]  out_rd;
   logic        out_valid;
   logic        out_ready;
   logic        wb_en;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic        err;

   int vectors = 0;
   int miscompares = 0;

   alu_operand_fetch dut (
      .clock       (clock),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .input_a     (input_a),
      .input_b     (input_b),
      .op          (op),
      .out_rd      (out_rd),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .err         (err)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wb(input logic [2:0] a, input logic [15:0] d);
      wb_en = 1'b1; wb_addr = a; wb_data = d;
      tick();
      wb_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; instr_valid = 1'b0; instr = 16'h0000; out_ready = 1'b1;
      wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0000;
      sample();
      chk("ready_in_reset", {15'd0, instr_ready}, 16'd0);
      tick(); tick();
      reset = 1'b0;
      sample();
      chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
      chk("rst_input_a", input_a, 16'd0);
      chk("rst_input_b", input_b, 16'd0);
      chk("rst_op", {12'd0, op}, 16'd0);
      chk("rst_out_rd", {13'd0, out_rd}, 16'd0);
      chk("rst_err", {15'd0, err}, 16'd0);

      // Basic issue: r1=5, r2=3, add r3,r1,r2
      tick();
      wb(3'd1, 16'd5);
      wb(3'd2, 16'd3);
      instr = 16'h0650; instr_valid = 1'b1;
      sample();
      chk("add_ready", {15'd0, instr_ready}, 16'd1);
      tick();
      sample();
      chk("add_a", input_a, 16'd5);
      chk("add_b", input_b, 16'd3);
      chk("add_op", {12'd0, op}, 16'd0);
      chk("add_rd", {13'd0, out_rd}, 16'd3);
      chk("add_valid", {15'd0, out_valid}, 16'd1);

      // RAW hazard: sub r4,r3,r1 waits for writeback of r3
      instr = 16'h18C8;
      sample();
      chk("sub_stall0", {15'd0, instr_ready}, 16'd0);
      tick();
      sample();
      chk("consumed_valid", {15'd0, out_valid}, 16'd0);
      chk("sub_stall1", {15'd0, instr_ready}, 16'd0);
      tick();
      wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'd8;
      sample();
`ifdef ALU_OPF_FWD_EN
      chk("wb_same_cycle_ready", {15'd0, instr_ready}, 16'd1);
      tick();
      wb_en = 1'b0; instr_valid = 1'b0;
`else
      chk("wb_same_cycle_ready", {15'd0, instr_ready}, 16'd0);
      tick();
      wb_en = 1'b0;
      sample();
      chk("after_wb_ready", {15'd0, instr_ready}, 16'd1);
      chk("bubble_valid", {15'd0, out_valid}, 16'd0);
      tick();
      instr_valid = 1'b0;
`endif
      sample();
      chk("sub_a", input_a, 16'd8);
      chk("sub_b", input_b, 16'd5);
      chk("sub_op", {12'd0, op}, 16'd1);
      chk("sub_rd", {13'd0, out_rd}, 16'd4);
      chk("sub_valid", {15'd0, out_valid}, 16'd1);

      // Backpressure: bundle held while out_ready=0
      out_ready = 1'b0;
      tick();
      instr = 16'h0A50; instr_valid = 1'b1;
      sample();
      chk("hold_valid", {15'd0, out_valid}, 16'd1);
      chk("hold_ready", {15'd0, instr_ready}, 16'd0);
      tick();
      sample();
      chk("hold_a", input_a, 16'd8);
      chk("hold_rd", {13'd0, out_rd}, 16'd4);
      tick();
      out_ready = 1'b1;
      sample();
      chk("release_ready", {15'd0, instr_ready}, 16'd1);
      tick();
      instr_valid = 1'b0;
      sample();
      chk("next_a", input_a, 16'd5);
      chk("next_b", input_b, 16'd3);
      chk("next_rd", {13'd0, out_rd}, 16'd5);
      chk("next_valid", {15'd0, out_valid}, 16'd1);
      wb(3'd4, 16'd1);
      wb(3'd5, 16'd2);

      // Illegal opcode 7 with rd=6: err pulse, nothing else changes
      instr = 16'h7C00; instr_valid = 1'b1;
      sample();
      chk("ill_ready", {15'd0, instr_ready}, 16'd1);
      tick();
      instr_valid = 1'b0;
      sample();
      chk("ill_err", {15'd0, err}, 16'd1);
      chk("ill_valid", {15'd0, out_valid}, 16'd0);
      tick();
      instr = 16'h0380;
      sample();
      chk("ill_err_clear", {15'd0, err}, 16'd0);
      chk("ill_no_pending", {15'd0, instr_ready}, 16'd1);

      // Immediate: add r0,r0,#5
      tick();
      instr = 16'h002C; instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      sample();
      chk("imm_a", input_a, 16'd0);
      chk("imm_b", input_b, 16'd5);
      chk("imm_rd", {13'd0, out_rd}, 16'd0);
      chk("imm_valid", {15'd0, out_valid}, 16'd1);

      // epar r3,r1,r2 sets pending[3]
      tick();
      instr = 16'h4650; instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      instr = 16'h021C;
      sample();
      chk("epar_op", {12'd0, op}, 16'd4);
      chk("epar_a", input_a, 16'd5);
      chk("epar_err", {15'd0, err}, 16'd0);
      chk("imm_rb_no_hazard", {15'd0, instr_ready}, 16'd1);
      instr = 16'h0218;
      #1;
      chk("reg_rb_hazard", {15'd0, instr_ready}, 16'd0);
      out_ready = 1'b0;

      // Reset mid-operation discards bundle, scoreboard and registers
      tick();
      reset = 1'b1;
      sample();
      chk("pre_rst_valid", {15'd0, out_valid}, 16'd1);
      chk("mid_rst_ready", {15'd0, instr_ready}, 16'd0);
      tick();
      reset = 1'b0; out_ready = 1'b1;
      instr = 16'h0650; instr_valid = 1'b1;
      sample();
      chk("mrst_valid", {15'd0, out_valid}, 16'd0);
      chk("mrst_a", input_a, 16'd0);
      chk("mrst_op", {12'd0, op}, 16'd0);
      chk("mrst_pending_clear", {15'd0, instr_ready}, 16'd1);
      tick();
      instr_valid = 1'b0;
      sample();
      chk("mrst_reg_a", input_a, 16'd0);
      chk("mrst_reg_b", input_b, 16'd0);
      chk("mrst_issue_valid", {15'd0, out_valid}, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_operand_fetch.md
# alu_operand_fetch

Operand-fetch/issue stage directly upstream of the 16-bit ALU. It accepts 16-bit instructions over a valid/ready handshake, decodes them, reads an 8×16 register file, and tracks in-flight destinations in a scoreboard. It presents a registered {input_a, input_b, op, rd} bundle to the ALU and accepts results back on a writeback port.

## Interface
- `NREG`, 8: register count; `rd`, `ra` and `rb` are 3 bits wide.
- `W`, 16: data width.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `instr_valid`  in  1  upstream instruction valid.
- `instr_ready`  out  1  stage can accept `instr` this cycle.
- `instr`  in  16  fields: op[15:12], rd[11:9], ra[8:6], rb[5:3], imm[2], unused[1:0].
- `input_a`  out  16  ALU operand A (registered).
- `input_b`  out  16  ALU operand B (registered).
- `op`  out  4  ALU opcode: 0 add, 1 sub, 2 and, 3 or, 4 epar.
- `out_rd`  out  3  destination register travelling with the operands.
- `out_valid`  out  1  operand bundle valid.
- `out_ready`  in  1  downstream consumed the bundle.
- `wb_en`  in  1  writeback strobe.
- `wb_addr`  in  3  writeback register.
- `wb_data`  in  16  writeback value.
- `err`  out  1  one-cycle pulse: illegal opcode dropped.

## Operation
- Accept occurs when `instr_valid && instr_ready`. `instr_ready = (!out_valid || out_ready) && !hazard`.
  - `instr_ready` never depends on `instr_valid`. It may depend combinationally on the `instr` fields.
- `hazard` is set when `pending[ra]`, `pending[rd]`, or `pending[rb]` is set. `pending[rb]` counts only when imm=0.
  - r0 is never pending.
- Operand A is `R[ra]`.
- Operand B is `R[rb]` when imm=0. When imm=1, it is {13'b0, rb field}, zero-extended.
- Register r0 reads 0. Writes to r0 are ignored.
- Legal op (0–4) on accept:
  - load `input_a`, `input_b`, `op`, `out_rd`; set `out_valid`;
  - set `pending[rd]` if rd≠0.
- Illegal op (5–15) on accept:
  - instruction is consumed and dropped;
  - `err`=1 for the next cycle only;
  - `out_valid` and `pending` are unchanged, unless a simultaneous downstream consume clears `out_valid`.
- Bundle consumed (`out_valid && out_ready`) with no new legal accept: `out_valid` goes to 0.
- `wb_en`: write `R[wb_addr] = wb_data` at the clock edge; clear `pending[wb_addr]`.
- Same-cycle set and clear of one pending bit: set wins.
- Writeback to a non-pending register is legal: the register file is written and `pending` is unaffected.

## Timing
- Reset values:
  - `out_valid`=0, `input_a`=0, `input_b`=0, `op`=0, `out_rd`=0, `err`=0;
  - `pending`=0;
  - all registers = 0.
- Latency: an instruction accepted at edge N is on the outputs with `out_valid`=1 after edge N.
- Throughput: 1 instruction per cycle when there is no hazard and `out_ready`=1.
- Output bundle is held stable while `out_valid && !out_ready`.
- Read-after-writeback, same cycle, without forwarding: the reader stalls one cycle because the pending bit clears at the edge.
- Reset asserted mid-operation:
  - all state returns to reset values at that edge;
  - an in-flight bundle is discarded;
  - `instr_ready` is 0 during the reset cycle.

## Configuration
- `ALU_OPF_FWD_EN` defined:
  - hazard logic ignores the pending bit for `wb_addr` when `wb_en`=1 in the same cycle;
  - the operand mux takes `wb_data` for that register (bypass);
  - result: no bubble on same-cycle writeback.
- `ALU_OPF_FWD_EN` undefined: no bypass; one-cycle stall as described in Timing.

## Structure
- Package `alu_pkg`:
  - opcode constants `ALU_ADD`=0, `ALU_SUB`=1, `ALU_AND`=2, `ALU_OR`=3, `ALU_EPAR`=4;
  - instruction field positions;
  - `W` and `NREG`.
- Sub-module `reg_file_8x16`:
  - two combinational read ports, one synchronous write port, synchronous reset;
  - r0 hardwired to zero.
- Scoreboard, decode and output register live in the top module.

## Test plan
- Reset, then writeback r1=5 and r2=3, then issue add r3,r1,r2 (0x0650) → next cycle `input_a`=5, `input_b`=3, `op`=0, `out_rd`=3, `out_valid`=1.
- Issue add r3 then sub r4,r3,r1 with no writeback → second instruction stalls (`instr_ready`=0) until `wb_en` r3=8. After that: `input_a`=8, `op`=1.
- Same-cycle writeback of r3 and a read of r3:
  - without `ALU_OPF_FWD_EN` → one bubble;
  - with it → accepted that cycle, `input_a`=`wb_data`.
- Hold `out_ready`=0 with a bundle valid → outputs stable; `instr_ready`=0; next instruction accepted the cycle `out_ready` rises.
- Opcode 7 → `err` pulses once; `out_valid` and `pending` unchanged. Imm instruction or r0,r0,imm=5 → `input_a`=0, `input_b`=5, no pending bit set.
- Assert `reset` with a bundle pending and `pending[3]` set → after the edge `out_valid`=0, `pending`=0, registers read 0.
